// File: rtl/id_ex_issue_stage.sv
// Purpose : IF/ID and ID/EX pipeline registers with load-use hazard detection and flush squash.
// Latency : one cycle from the fetch inputs to IF/ID, and one more cycle to the ex_* outputs.
// Backpress: on a load-use hazard, stall_out freezes fetch and IF/ID holds while bubbles enter EX.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   if_*_in            instruction / 25-bit control bundle / PC+4 presented by fetch
//   flush_in           redirect resolved in EX; squashes ID and EX contents
//   stall_out          combinational: fetch must hold its PC and keep presenting the same instruction
//   ex_*_out           ID/EX register contents; ex_valid_out = 0 marks a bubble
//   hazard_count_out   saturating count of load-use hazards detected since reset
module id_ex_issue_stage #(
  parameter logic [31:0] NOP_INSTR    = 32'h34000000,
  parameter logic [24:0] NOP_BUNDLE   = 25'h0862031,
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_instruction_in,
  input  logic [24:0] if_bundle_in,
  input  logic [31:0] if_pc_seq_in,
  input  logic        flush_in,
  output logic        stall_out,
  output logic [31:0] ex_instruction_out,
  output logic [24:0] ex_bundle_out,
  output logic [31:0] ex_pc_seq_out,
  output logic        ex_valid_out,
  output logic [15:0] hazard_count_out
);

  typedef enum logic {RUN, STALL} state_t;

  // The hazard cycle itself supplies the first bubble, so STALL only covers the rest.
  localparam logic [3:0] CNT_RELOAD = (STALL_CYCLES > 1) ? 4'(STALL_CYCLES - 2) : 4'd0;

  logic [31:0] id_instr_q, id_instr_d;
  logic [24:0] id_bundle_q, id_bundle_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;

  logic [31:0] ex_instr_q, ex_instr_d;
  logic [24:0] ex_bundle_q, ex_bundle_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic        ex_valid_q, ex_valid_d;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] hcnt_q, hcnt_d;

  logic [4:0]  ex_dest;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        hazard;

  // Bundle bit15 picks rd for R-type writers, otherwise rt is the destination.
  assign ex_dest = ex_bundle_q[15] ? ex_instr_q[15:11] : ex_instr_q[20:16];
  assign id_rs   = id_instr_q[25:21];
  assign id_rt   = id_instr_q[20:16];

  // Only a register-writing load in EX can create a load-use hazard; $zero never does.
  assign hazard = id_valid_q && ex_valid_q &&
                  ex_bundle_q[2] && ex_bundle_q[0] &&
                  (ex_dest != 5'd0) &&
                  ((ex_dest == id_rs) || (ex_dest == id_rt));

  assign stall_out = ((state_q == RUN) && hazard && !flush_in) ||
                     ((state_q == STALL) && !flush_in);

  always_comb begin
    id_instr_d  = id_instr_q;
    id_bundle_d = id_bundle_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;
    ex_instr_d  = ex_instr_q;
    ex_bundle_d = ex_bundle_q;
    ex_pc_d     = ex_pc_q;
    ex_valid_d  = ex_valid_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;

    if (flush_in) begin
      ex_instr_d  = NOP_INSTR;
      ex_bundle_d = NOP_BUNDLE;
      ex_pc_d     = 32'd0;
      ex_valid_d  = 1'b0;
      id_instr_d  = if_instruction_in;
      id_bundle_d = if_bundle_in;
      id_pc_d     = if_pc_seq_in;
      id_valid_d  = 1'b1;
      state_d     = RUN;
      cnt_d       = 4'd0;
    end else if ((state_q == RUN) && hazard) begin
      ex_instr_d  = NOP_INSTR;
      ex_bundle_d = NOP_BUNDLE;
      ex_pc_d     = 32'd0;
      ex_valid_d  = 1'b0;
      if (hcnt_q != 16'hFFFF) begin
        hcnt_d = hcnt_q + 16'd1;
      end
      if (STALL_CYCLES > 1) begin
        state_d = STALL;
        cnt_d   = CNT_RELOAD;
      end
    end else if (state_q == STALL) begin
      ex_instr_d  = NOP_INSTR;
      ex_bundle_d = NOP_BUNDLE;
      ex_pc_d     = 32'd0;
      ex_valid_d  = 1'b0;
      if (cnt_q == 4'd0) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else begin
      ex_instr_d  = id_instr_q;
      ex_bundle_d = id_bundle_q;
      ex_pc_d     = id_pc_q;
      ex_valid_d  = id_valid_q;
      id_instr_d  = if_instruction_in;
      id_bundle_d = if_bundle_in;
      id_pc_d     = if_pc_seq_in;
      id_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_instr_q  <= NOP_INSTR;
      id_bundle_q <= NOP_BUNDLE;
      id_pc_q     <= 32'd0;
      id_valid_q  <= 1'b0;
      ex_instr_q  <= NOP_INSTR;
      ex_bundle_q <= NOP_BUNDLE;
      ex_pc_q     <= 32'd0;
      ex_valid_q  <= 1'b0;
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      hcnt_q      <= 16'd0;
    end else begin
      id_instr_q  <= id_instr_d;
      id_bundle_q <= id_bundle_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
      ex_instr_q  <= ex_instr_d;
      ex_bundle_q <= ex_bundle_d;
      ex_pc_q     <= ex_pc_d;
      ex_valid_q  <= ex_valid_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
    end
  end

  assign ex_instruction_out = ex_instr_q;
  assign ex_bundle_out      = ex_bundle_q;
  assign ex_pc_seq_out      = ex_pc_q;
  assign ex_valid_out       = ex_valid_q;
  assign hazard_count_out   = hcnt_q;

endmodule

// File: doc/id_ex_issue_stage.md
Name: id_ex_issue_stage

Overview:
- Consumer end of the fetch interface. Captures the instruction, 25-bit control bundle and sequential PC from the fetch stage into an IF/ID register.
- Detects load-use RAW hazards against the instruction in EX. On a hazard it holds the IF/ID register, tells fetch to freeze its PC and injects bubbles into the ID/EX register.
- Also squashes wrong-path work on a control-flow flush from EX.

Parameters:
- NOP_INSTR, 32'h34000000, bubble instruction (ori $zero,$zero,0).
- NOP_BUNDLE, 25'h0862031, bubble control bundle, matching the fetch-side no-op bundle.
- STALL_CYCLES, 1, number of bubbles per load-use hazard; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- if_instruction_in  in  32  instruction from fetch.
- if_bundle_in  in  25  control bundle from fetch.
- if_pc_seq_in  in  32  PC+4 from fetch.
- flush_in  in  1  branch/jump redirect resolved in EX.
- stall_out  out  1  to fetch: 1 = hold PC and keep presenting the same instruction.
- ex_instruction_out  out  32  ID/EX instruction.
- ex_bundle_out  out  25  ID/EX bundle.
- ex_pc_seq_out  out  32  ID/EX PC+4.
- ex_valid_out  out  1  ID/EX holds a real (non-bubble) instruction.
- hazard_count_out  out  16  saturating count of hazards detected since reset.

Behaviour:
- Bundle fields used:
  - bit0 regfile_we
  - bit2 data_mem_re (load)
  - bit15 dest select: 1 selects rd = instr[15:11]; 0 selects rt = instr[20:16].
- Source registers: rs = instr[25:21], rt = instr[20:16].
- Reset, asynchronous:
  - IF/ID = NOP_INSTR / NOP_BUNDLE / 0, with id_valid = 0.
  - ID/EX outputs = NOP_INSTR / NOP_BUNDLE / 0, with ex_valid_out = 0.
  - State = RUN, counter = 0, hazard_count_out = 0, stall_out = 0.
  - Reset mid-stall drops the stall immediately.
- hazard, combinational, is true only when all of the following hold:
  - id_valid and ex_valid_out.
  - EX bundle has bit2 = 1 and bit0 = 1.
  - EX dest != 0.
  - EX dest equals ID rs or ID rt.
  - $zero never hazards.
- FSM states: RUN and STALL, with a 4-bit counter cnt.
- stall_out = (RUN & hazard & ~flush_in) | (STALL & ~flush_in). It is combinational so fetch freezes in the same cycle.
- Each rising edge, priority high to low:
  1. flush_in:
     - ID/EX loads the bubble (NOP_INSTR, NOP_BUNDLE, valid 0).
     - IF/ID loads the fetch inputs with valid 1.
     - State goes to RUN and cnt = 0.
     - Flush overrides any stall.
  2. RUN & hazard:
     - ID/EX loads the bubble and IF/ID holds.
     - hazard_count increments (saturating at 16'hFFFF).
     - If STALL_CYCLES > 1: go to STALL with cnt = STALL_CYCLES-2.
     - Otherwise stay in RUN.
  3. STALL:
     - ID/EX loads the bubble and IF/ID holds.
     - If cnt == 0, go to RUN; otherwise cnt decrements.
  4. RUN, no hazard:
     - ID/EX <- IF/ID contents.
     - IF/ID <- fetch inputs with valid 1.
- Latency: one cycle from the fetch inputs to IF/ID, and one more to the ex_* outputs.
- A hazard costs exactly STALL_CYCLES bubbles.
- After a STALL_CYCLES = 1 bubble, the load has left EX, so hazard deasserts naturally.
- No hazard is checked against a bubble, because ex_valid_out = 0.
- Simultaneous hazard and flush: flush wins, the hazard is not counted, and the instruction in ID is discarded.
- pc_seq is passed through unmodified; no arithmetic is done on it.

Test Plan:
1. Reset mid-stream: assert reset asynchronously between edges -> all ex_* outputs show the NOP values with ex_valid_out = 0, stall_out = 0 and hazard_count_out = 0 immediately, without waiting for an edge.
2. Independent stream: lw $t0 then add $t2,$t3,$t4 -> no stall; add appears on ex_instruction_out exactly 2 cycles after it is presented.
3. Load-use, STALL_CYCLES = 1: lw $t0,0($s0) then add $t1,$t0,$t2 -> stall_out = 1 for exactly 1 cycle; ex_* shows lw, then the bubble (NOP, valid 0), then add; hazard_count_out = 1.
4. Load-use, STALL_CYCLES = 3: same sequence -> stall_out high for 3 consecutive cycles and 3 bubbles enter EX; the same fetch instruction is held throughout.
5. Zero destination: lw $zero,0($s0) then add $t1,$zero,$t2 -> no stall and hazard_count_out stays 0.
6. Flush during a stall: assert flush_in in the first STALL cycle (STALL_CYCLES = 3) -> stall_out drops that cycle; EX gets a bubble; IF/ID takes the target instruction; state returns to RUN; the held add never reaches EX.
